// File: rtl/corr_fifo_ctrl.sv
// corr_fifo_ctrl
//   Buffers sparse validated correspondences (idx0, idx1, depth0) from the
//   line-buffer / depth-check stage in a circular FIFO and hands them to the
//   Jacobian/accumulate stage over ready/valid. Tracks frame boundaries,
//   counts accepted and dropped entries per frame, and raises frame-end only
//   once every buffered entry has left the block.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_frame_start/end     frame delimiter pulses from upstream
//   i_valid + i_idx*/i_depth0   incoming correspondence (no upstream stall)
//   i_ready               downstream accept
//   o_valid + o_idx*/o_depth0   output entry (1-entry output register)
//   o_frame_start/end     registered frame pulses (end only after drain)
//   o_corr_cnt            entries accepted this frame (saturating)
//   o_overflow            sticky drop flag for this frame
//   o_drop_cnt            entries dropped this frame (saturating at 255)
module corr_fifo_ctrl #(
  parameter int DEPTH  = 64,
  parameter int H_BW   = 10,
  parameter int V_BW   = 9,
  parameter int D_BW   = 16,
  parameter int CNT_BW = 19
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_frame_start,
  input  logic              i_frame_end,
  input  logic              i_valid,
  input  logic [H_BW-1:0]   i_idx0_x,
  input  logic [V_BW-1:0]   i_idx0_y,
  input  logic [H_BW-1:0]   i_idx1_x,
  input  logic [V_BW-1:0]   i_idx1_y,
  input  logic [D_BW-1:0]   i_depth0,
  input  logic              i_ready,
  output logic              o_frame_start,
  output logic              o_frame_end,
  output logic              o_valid,
  output logic [H_BW-1:0]   o_idx0_x,
  output logic [V_BW-1:0]   o_idx0_y,
  output logic [H_BW-1:0]   o_idx1_x,
  output logic [V_BW-1:0]   o_idx1_y,
  output logic [D_BW-1:0]   o_depth0,
  output logic [CNT_BW-1:0] o_corr_cnt,
  output logic              o_overflow,
  output logic [7:0]        o_drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int ENT_W = 2 * H_BW + 2 * V_BW + D_BW;
  localparam logic [AW:0] OCC_FULL = (AW + 1)'(DEPTH);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  function automatic logic [CNT_BW-1:0] sat_inc_cnt(input logic [CNT_BW-1:0] v);
    return (&v) ? v : v + CNT_BW'(1);
  endfunction

  function automatic logic [7:0] sat_inc_drop(input logic [7:0] v);
    return (&v) ? v : v + 8'd1;
  endfunction

  logic [1:0]       state;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] ent_p0;
  logic [ENT_W-1:0] ent_p1;
  logic             vld_p1;
  logic             wr_req;
  logic             fifo_full;
  logic             wr_en;
  logic             drop;
  logic             ld_p1;
  logic             start_acc;

  assign ent_p0    = {i_idx0_x, i_idx0_y, i_idx1_x, i_idx1_y, i_depth0};
  assign wr_req    = (state == ST_ACTIVE) && i_valid;
  // Fullness uses the occupancy before this cycle's pop, so a simultaneous
  // pop never makes room for the write arriving in the same cycle.
  assign fifo_full = (occ == OCC_FULL);
  assign wr_en     = wr_req && !fifo_full;
  assign drop      = wr_req && fifo_full;
  // Output register refills whenever it is empty or is being consumed.
  assign ld_p1     = (occ != '0) && (!vld_p1 || i_ready);
  assign start_acc = (state == ST_IDLE) && i_frame_start;

  // ---- stage p0: FIFO storage (contents are never reset) ----
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= ent_p0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (ld_p1) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_en, ld_p1})
        2'b10:   occ <= occ + (AW + 1)'(1);
        2'b01:   occ <= occ - (AW + 1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  // ---- stage p1: output register ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      vld_p1 <= 1'b0;
      ent_p1 <= '0;
    end else begin
      if (ld_p1) begin
        vld_p1 <= 1'b1;
        ent_p1 <= mem[rd_ptr];
      end else if (i_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign o_valid = vld_p1;
  assign {o_idx0_x, o_idx0_y, o_idx1_x, o_idx1_y, o_depth0} = ent_p1;

  // ---- frame control and per-frame statistics ----
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= ST_IDLE;
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;
      o_corr_cnt    <= '0;
      o_overflow    <= 1'b0;
      o_drop_cnt    <= '0;
    end else begin
      o_frame_start <= 1'b0;
      o_frame_end   <= 1'b0;

      if (start_acc) begin
        o_corr_cnt <= '0;
        o_overflow <= 1'b0;
        o_drop_cnt <= '0;
      end else begin
        if (wr_en) begin
          o_corr_cnt <= sat_inc_cnt(o_corr_cnt);
        end
        if (drop) begin
          o_overflow <= 1'b1;
          o_drop_cnt <= sat_inc_drop(o_drop_cnt);
        end
      end

      case (state)
        ST_IDLE: begin
          if (i_frame_start) begin
            state         <= ST_ACTIVE;
            o_frame_start <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (i_frame_end) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Frame end waits until both the FIFO and the output slot are empty.
          if ((occ == '0) && !vld_p1) begin
            o_frame_end <= 1'b1;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_corr_fifo_ctrl.sv
module tb_corr_fifo_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_frame_start;
  logic        i_frame_end;
  logic        i_valid;
  logic [9:0]  i_idx0_x;
  logic [8:0]  i_idx0_y;
  logic [9:0]  i_idx1_x;
  logic [8:0]  i_idx1_y;
  logic [15:0] i_depth0;
  logic        i_ready;
  logic        o_frame_start;
  logic        o_frame_end;
  logic        o_valid;
  logic [9:0]  o_idx0_x;
  logic [8:0]  o_idx0_y;
  logic [9:0]  o_idx1_x;
  logic [8:0]  o_idx1_y;
  logic [15:0] o_depth0;
  logic [18:0] o_corr_cnt;
  logic        o_overflow;
  logic [7:0]  o_drop_cnt;

  int checks = 0;
  int errors = 0;
  logic [53:0] exp_q[$];

  corr_fifo_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_frame_start(i_frame_start), .i_frame_end(i_frame_end),
    .i_valid(i_valid),
    .i_idx0_x(i_idx0_x), .i_idx0_y(i_idx0_y),
    .i_idx1_x(i_idx1_x), .i_idx1_y(i_idx1_y),
    .i_depth0(i_depth0), .i_ready(i_ready),
    .o_frame_start(o_frame_start), .o_frame_end(o_frame_end),
    .o_valid(o_valid),
    .o_idx0_x(o_idx0_x), .o_idx0_y(o_idx0_y),
    .o_idx1_x(o_idx1_x), .o_idx1_y(o_idx1_y),
    .o_depth0(o_depth0), .o_corr_cnt(o_corr_cnt),
    .o_overflow(o_overflow), .o_drop_cnt(o_drop_cnt)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Entry t,i: distinct recognisable values per test t and index i.
  function automatic logic [53:0] mk(input int t, input int i);
    logic [9:0]  x0;
    logic [8:0]  y0;
    logic [9:0]  x1;
    logic [8:0]  y1;
    logic [15:0] d;
    x0 = 10'(t * 100 + i);
    y0 = 9'(i * 3);
    x1 = 10'(1023 - i);
    y1 = 9'(t * 50 + i);
    d  = 16'(t * 4096 + i);
    return {x0, y0, x1, y1, d};
  endfunction

  function automatic logic [53:0] out_ent();
    return {o_idx0_x, o_idx0_y, o_idx1_x, o_idx1_y, o_depth0};
  endfunction

  task automatic drive(input logic [53:0] e);
    {i_idx0_x, i_idx0_y, i_idx1_x, i_idx1_y, i_depth0} = e;
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  task automatic wait_fe(input int limit, output int n, output logic found);
    n = 0;
    found = 1'b0;
    while (!found && n < limit) begin
      step();
      n++;
      if (o_frame_end) found = 1'b1;
    end
  endtask

  // Scoreboard monitor: every transfer must match the next expected entry,
  // and frame end must never appear while entries are still owed.
  always @(negedge i_clk) begin
    logic [53:0] e;
    if (!i_rst && o_valid && i_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected got=%0h expected=none", out_ent());
      end else begin
        e = exp_q.pop_front();
        if (out_ent() !== e) begin
          errors++;
          $display("FAIL out_entry got=%0h expected=%0h", out_ent(), e);
        end
      end
    end
    if (o_frame_end) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL fe_early got=%0d_pending expected=0_pending", exp_q.size());
      end
    end
  end

  initial begin
    int   n;
    logic found;
    logic [53:0] e;
    i_rst = 1'b1; i_frame_start = 1'b0; i_frame_end = 1'b0; i_valid = 1'b0;
    i_ready = 1'b0;
    drive('0);
    repeat (3) step();
    chk("rst_valid", o_valid, 0);
    chk("rst_fs", o_frame_start, 0);
    chk("rst_fe", o_frame_end, 0);
    chk("rst_cnt", o_corr_cnt, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_drop", o_drop_cnt, 0);
    chk("rst_data", out_ent(), 0);
    i_rst = 1'b0;
    step();

    // T1: 10 back-to-back entries, ready held, frame end with the last one.
    i_ready = 1'b1;
    i_frame_start = 1'b1;
    step();
    chk("t1_fs_pulse", o_frame_start, 1);
    i_frame_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive(mk(1, i));
      i_valid = 1'b1;
      i_frame_end = (i == 9);
      exp_q.push_back(mk(1, i));
      step();
      if (i == 0) begin
        chk("t1_lat_lo", o_valid, 0);
        chk("t1_fs_one", o_frame_start, 0);
      end
      if (i == 1) chk("t1_lat_hi", o_valid, 1);
    end
    i_valid = 1'b0;
    i_frame_end = 1'b0;
    wait_fe(100, n, found);
    chk("t1_fe_found", found, 1);
    chk("t1_fe_delay", n, 3);
    chk("t1_cnt", o_corr_cnt, 10);
    chk("t1_drop", o_drop_cnt, 0);
    chk("t1_ovf", o_overflow, 0);
    step();
    chk("t1_fe_pulse", o_frame_end, 0);

    // T2: 70 entries with ready low; 64 stored plus 1 in output register.
    i_ready = 1'b0;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    chk("t2_cnt_clr", o_corr_cnt, 0);
    for (int i = 0; i < 70; i++) begin
      drive(mk(2, i));
      i_valid = 1'b1;
      if (i < 65) exp_q.push_back(mk(2, i));
      step();
    end
    i_valid = 1'b0;
    chk("t2_ovf", o_overflow, 1);
    chk("t2_drop", o_drop_cnt, 5);
    chk("t2_cnt", o_corr_cnt, 65);
    chk("t2_hold_vld", o_valid, 1);
    e = mk(2, 0);
    chk("t2_hold_data", out_ent(), e);
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    i_ready = 1'b1;
    wait_fe(200, n, found);
    chk("t2_fe_found", found, 1);
    chk("t2_cnt_end", o_corr_cnt, 65);
    chk("t2_drop_end", o_drop_cnt, 5);

    // T3: drain 5 entries with ready toggling; i_valid during drain ignored.
    i_ready = 1'b0;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    chk("t3_ovf_clr", o_overflow, 0);
    chk("t3_drop_clr", o_drop_cnt, 0);
    for (int i = 0; i < 5; i++) begin
      drive(mk(3, i));
      i_valid = 1'b1;
      exp_q.push_back(mk(3, i));
      step();
    end
    i_valid = 1'b0;
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    found = 1'b0;
    for (int j = 0; j < 60 && !found; j++) begin
      drive(mk(9, j));
      i_valid = 1'b1;
      i_ready = ~i_ready;
      step();
      if (o_frame_end) found = 1'b1;
    end
    i_valid = 1'b0;
    chk("t3_fe_found", found, 1);
    chk("t3_cnt", o_corr_cnt, 5);

    // T4: frame start while ACTIVE is ignored.
    i_ready = 1'b1;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(4, i));
      i_valid = 1'b1;
      exp_q.push_back(mk(4, i));
      step();
    end
    i_valid = 1'b0;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    chk("t4_no_fs", o_frame_start, 0);
    chk("t4_cnt_kept", o_corr_cnt, 3);
    i_frame_end = 1'b1;
    step();
    i_frame_end = 1'b0;
    wait_fe(100, n, found);
    chk("t4_fe_found", found, 1);
    chk("t4_cnt", o_corr_cnt, 3);

    // T5: reset mid-frame with 20 buffered, then a clean frame.
    i_ready = 1'b0;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(mk(5, i));
      i_valid = 1'b1;
      step();
    end
    i_valid = 1'b0;
    chk("t5_pre_cnt", o_corr_cnt, 20);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("t5_rst_vld", o_valid, 0);
    chk("t5_rst_cnt", o_corr_cnt, 0);
    chk("t5_rst_ovf", o_overflow, 0);
    chk("t5_rst_drop", o_drop_cnt, 0);
    i_ready = 1'b1;
    i_frame_start = 1'b1;
    step();
    i_frame_start = 1'b0;
    chk("t5_fs_pulse", o_frame_start, 1);
    for (int i = 0; i < 2; i++) begin
      drive(mk(6, i));
      i_valid = 1'b1;
      i_frame_end = (i == 1);
      exp_q.push_back(mk(6, i));
      step();
    end
    i_valid = 1'b0;
    i_frame_end = 1'b0;
    wait_fe(100, n, found);
    chk("t5_fe_found", found, 1);
    chk("t5_cnt", o_corr_cnt, 2);
    step();
    chk("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
